// File: rtl/pic_ctrl_sync.sv
// 8259A-style PIC control: ICW/OCW decode, mask/mode registers, two-pulse INTA
// handshake, vector and cascade drive. Single clock, synchronous active-high reset.
module pic_ctrl_sync #(
    parameter int N_IRQ        = 8,
    parameter int IDX_W        = 3,
    parameter int SPURIOUS_IDX = N_IRQ - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_stb,
    input  logic             a0,
    input  logic [7:0]       data_in,
    input  logic             sp,
    input  logic             inta_n,
    input  logic [IDX_W-1:0] int_idx,
    input  logic             int_valid,
    input  logic [2:0]       cas_in,
    output logic [2:0]       cas_out,
    output logic             cas_oe,
    output logic [N_IRQ-1:0] imr,
    output logic             ltim,
    output logic             aeoi,
    output logic             sfnm,
    output logic [1:0]       read_cmd,
    output logic [7:0]       ocw2_op,
    output logic             ocw2_stb,
    output logic             init_done,
    output logic             ack1,
    output logic             ack2,
    output logic [7:0]       vec_out,
    output logic             vec_valid,
    output logic             eoi_stb,
    output logic [IDX_W-1:0] eoi_idx
);
    typedef enum logic [1:0] {I_IDLE, I_W2, I_W3, I_W4} init_t;
    typedef enum logic [1:0] {A_IDLE, A_ACK1, A_ACK2}   ack_t;

    init_t ist, ist_nx;
    ack_t  ast, ast_nx;

    logic             sngl, ic4, inta_q, casc, slave;
    logic [7:0]       icw2, icw3;
    logic [IDX_W-1:0] idx, idx_new;
    logic             icw1_wr, fall, rise, fin, eoi_nx, enter;

    assign icw1_wr = wr_stb & ~a0 & data_in[4];
    assign fall    = inta_q & ~inta_n;
    assign rise    = ~inta_q & inta_n;
    assign idx_new = int_valid ? int_idx : IDX_W'(SPURIOUS_IDX);
    assign enter   = (ast == A_IDLE) && (ast_nx == A_ACK1);

    // Init sequencer; fin marks the write that completes initialisation.
    always_comb begin
        ist_nx = ist;
        fin    = 1'b0;
        if (icw1_wr) begin
            ist_nx = I_W2;
        end else if (wr_stb && a0) begin
            case (ist)
                I_W2: begin
                    if (!sngl)   ist_nx = I_W3;
                    else if (ic4) ist_nx = I_W4;
                    else begin ist_nx = I_IDLE; fin = 1'b1; end
                end
                I_W3: begin
                    if (ic4) ist_nx = I_W4;
                    else begin ist_nx = I_IDLE; fin = 1'b1; end
                end
                I_W4: begin ist_nx = I_IDLE; fin = 1'b1; end
                default: ;
            endcase
        end
    end

    // Acknowledge sequencer; an ICW1 write overrides any INTA edge.
    always_comb begin
        ast_nx = ast;
        eoi_nx = 1'b0;
        if (icw1_wr) begin
            ast_nx = A_IDLE;
        end else begin
            case (ast)
                A_IDLE: if (fall && init_done) ast_nx = A_ACK1;
                A_ACK1: if (fall) ast_nx = A_ACK2;
                A_ACK2: if (rise) begin ast_nx = A_IDLE; eoi_nx = aeoi; end
                default: ast_nx = A_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ist <= I_IDLE;  ast <= A_IDLE;  inta_q <= 1'b1;
            sngl <= 1'b0;   ic4 <= 1'b0;    icw2 <= '0;  icw3 <= '0;
            idx <= '0;      casc <= 1'b0;   slave <= 1'b0;
            imr <= '0;      ltim <= 1'b0;   aeoi <= 1'b0; sfnm <= 1'b0;
            read_cmd <= '0; ocw2_op <= '0;  ocw2_stb <= 1'b0;
            init_done <= 1'b0; ack1 <= 1'b0; ack2 <= 1'b0;
            eoi_stb <= 1'b0;   eoi_idx <= '0;
        end else begin
            ist      <= ist_nx;
            ast      <= ast_nx;
            inta_q   <= inta_n;
            ack1     <= (ast_nx == A_ACK1);
            ack2     <= (ast_nx == A_ACK2);
            eoi_stb  <= eoi_nx;
            eoi_idx  <= eoi_nx ? idx : '0;
            ocw2_stb <= 1'b0;
            // Cascade/slave path is decided once, at the first pulse.
            if (enter) begin
                idx   <= idx_new;
                casc  <= ~sngl & sp & icw3[idx_new];
                slave <= ~sngl & ~sp;
            end
            if (icw1_wr) begin
                ltim <= data_in[3];  sngl <= data_in[1];  ic4 <= data_in[0];
                imr  <= '0;          aeoi <= 1'b0;        sfnm <= 1'b0;
                init_done <= 1'b0;
            end else if (wr_stb && a0) begin
                case (ist)
                    I_W2: icw2 <= data_in;
                    I_W3: icw3 <= data_in;
                    I_W4: begin aeoi <= data_in[1]; sfnm <= data_in[4]; end
                    default: if (init_done) imr <= data_in[N_IRQ-1:0];
                endcase
            end else if (wr_stb && init_done) begin
                if (data_in[3]) read_cmd <= data_in[1:0];
                else begin ocw2_op <= data_in; ocw2_stb <= 1'b1; end
            end
            if (fin) init_done <= 1'b1;
        end
    end

    assign cas_oe    = casc && (ast != A_IDLE);
    assign cas_out   = cas_oe ? 3'(idx) : 3'd0;
    assign vec_valid = (ast == A_ACK2) && (slave ? (cas_in == icw3[2:0]) : ~casc);
    assign vec_out   = vec_valid ? {icw2[7:IDX_W], idx} : 8'h00;
endmodule

// File: tb/tb_pic_ctrl_sync.sv
// Randomised bench for pic_ctrl_sync: transaction-level model of the mode
// registers and expected vector/cascade behaviour of each acknowledge.
module tb_pic_ctrl_sync;
    localparam int N_IRQ = 8;
    localparam int IDX_W = 3;

    logic clk = 0, rst = 1, wr_stb = 0, a0 = 0, sp = 1, inta_n = 1, int_valid = 0;
    logic [7:0] data_in = 0;
    logic [2:0] int_idx = 0, cas_in = 0;
    logic [2:0] cas_out;  logic cas_oe, ltim, aeoi, sfnm, ocw2_stb, init_done;
    logic [N_IRQ-1:0] imr; logic [1:0] read_cmd; logic [7:0] ocw2_op, vec_out;
    logic ack1, ack2, vec_valid, eoi_stb; logic [IDX_W-1:0] eoi_idx;

    pic_ctrl_sync #(.N_IRQ(N_IRQ), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .wr_stb(wr_stb), .a0(a0), .data_in(data_in), .sp(sp),
        .inta_n(inta_n), .int_idx(int_idx), .int_valid(int_valid), .cas_in(cas_in),
        .cas_out(cas_out), .cas_oe(cas_oe), .imr(imr), .ltim(ltim), .aeoi(aeoi),
        .sfnm(sfnm), .read_cmd(read_cmd), .ocw2_op(ocw2_op), .ocw2_stb(ocw2_stb),
        .init_done(init_done), .ack1(ack1), .ack2(ack2), .vec_out(vec_out),
        .vec_valid(vec_valid), .eoi_stb(eoi_stb), .eoi_idx(eoi_idx));

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    // model state
    logic m_sngl, m_aeoi, m_sfnm, m_ltim;
    logic [7:0] m_icw2 = 0, m_icw3 = 0, m_imr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        a0 = a; data_in = d; wr_stb = 1; tick;
        wr_stb = 0; a0 = 0; data_in = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {cas_out, cas_oe, imr, ltim, aeoi, sfnm, read_cmd, ocw2_op, ocw2_stb,
                  init_done, ack1, ack2, vec_out, vec_valid, eoi_stb, eoi_idx}, 64'd0);
    endtask

    task automatic do_init(input logic [7:0] i1, i2, i3, i4);
        wr(0, i1); wr(1, i2);
        if (!i1[1]) wr(1, i3);
        if (i1[0])  wr(1, i4);
        m_sngl = i1[1]; m_ltim = i1[3]; m_icw2 = i2;
        if (!i1[1]) m_icw3 = i3;
        m_aeoi = i1[0] & i4[1]; m_sfnm = i1[0] & i4[4]; m_imr = 0;
        chk("init_done", init_done, 1);
        chk("ltim", ltim, m_ltim);
        chk("aeoi", aeoi, m_aeoi);
        chk("sfnm", sfnm, m_sfnm);
        chk("imr_init", imr, 0);
    endtask

    // One full acknowledge; int_idx/int_valid are scrambled after the first pulse.
    task automatic hs(input logic [2:0] i, input logic v, input logic [2:0] ci);
        logic [2:0] e; logic casc, slv, vv;
        e    = v ? i : 3'(N_IRQ - 1);
        casc = !m_sngl && sp && m_icw3[e];
        slv  = !m_sngl && !sp;
        int_idx = i; int_valid = v; inta_n = 0; tick;
        chk("ack1", ack1, 1);
        chk("ack2_in_ack1", ack2, 0);
        chk("cas_oe_ack1", cas_oe, casc);
        if (casc) chk("cas_out_ack1", cas_out, e);
        chk("vec_valid_ack1", vec_valid, 0);
        int_idx = ~i; int_valid = ~v; tick;
        chk("ack1_held_low", ack1, 1);
        inta_n = 1; tick;
        chk("ack1_rise_ignored", ack1, 1);
        inta_n = 0; cas_in = ci; tick;
        chk("ack2", {ack1, ack2}, 2'b01);
        vv = slv ? (ci == m_icw3[2:0]) : !casc;
        chk("vec_valid", vec_valid, vv);
        if (vv) chk("vec_out", vec_out, {m_icw2[7:3], e});
        chk("cas_oe_ack2", cas_oe, casc);
        if (casc) chk("cas_out_ack2", cas_out, e);
        inta_n = 1; tick;
        chk("ack2_exit", {ack1, ack2}, 2'b00);
        chk("eoi_stb", eoi_stb, m_aeoi);
        if (m_aeoi) chk("eoi_idx", eoi_idx, e);
        chk("cas_oe_idle", cas_oe, 0);
        tick;
        chk("eoi_stb_pulse", eoi_stb, 0);
    endtask

    task automatic ocw_rand;
        logic [7:0] d; logic [2:0] k;
        d = 8'($urandom); k = 3'($urandom_range(0, 2));
        if (k == 0) begin
            wr(1, d); m_imr = d;
            chk("imr_ocw1", imr, m_imr);
        end else if (k == 1) begin
            d = (d & 8'hE7);
            wr(0, d);
            chk("ocw2_op", ocw2_op, d);
            chk("ocw2_stb", ocw2_stb, 1);
            tick;
            chk("ocw2_stb_pulse", ocw2_stb, 0);
        end else begin
            d = (d & 8'hE7) | 8'h08;
            wr(0, d);
            chk("read_cmd", read_cmd, d[1:0]);
            chk("ocw2_stb_ocw3", ocw2_stb, 0);
        end
    endtask

    initial begin
        logic [7:0] r1, r2, r3, r4; logic [2:0] ri, rc; int mode;
        tick; tick;
        chk_zero("reset_state");
        rst = 0; tick;
        chk_zero("after_reset");

        // edge before init is ignored
        inta_n = 0; tick; chk("no_ack_before_init", ack1, 0); inta_n = 1; tick;

        // single mode, AEOI
        sp = 1;
        do_init(8'h13, 8'h40, 8'h00, 8'h03);
        hs(3'd5, 1, 3'd0);
        hs(3'd2, 0, 3'd0);                      // spurious -> 0x47

        // OCWs
        wr(1, 8'hF0); m_imr = 8'hF0; chk("imr_f0", imr, 8'hF0);
        wr(0, 8'h20); chk("ocw2_20", ocw2_op, 8'h20); chk("ocw2_stb_20", ocw2_stb, 1);
        tick; chk("ocw2_stb_20_end", ocw2_stb, 0);
        wr(0, 8'h0B); chk("read_cmd_0b", read_cmd, 2'b11);

        // master cascade
        sp = 1;
        do_init(8'h11, 8'h08, 8'h04, 8'h01);
        hs(3'd2, 1, 3'd0);
        hs(3'd3, 1, 3'd0);

        // slave
        sp = 0;
        do_init(8'h11, 8'h70, 8'h02, 8'h01);
        hs(3'd4, 1, 3'd2);
        hs(3'd4, 1, 3'd3);

        // ICW1 coincident with falling edge wins
        sp = 1;
        do_init(8'h13, 8'h40, 8'h00, 8'h03);
        inta_n = 0; a0 = 0; data_in = 8'h13; wr_stb = 1; tick;
        wr_stb = 0; data_in = 0;
        chk("icw1_beats_inta", ack1, 0);
        chk("icw1_clears_done", init_done, 0);
        inta_n = 1; tick;
        do_init(8'h13, 8'h40, 8'h00, 8'h03);

        // abort during ACK1
        wr(1, 8'h5A); chk("imr_5a", imr, 8'h5A);
        inta_n = 0; int_valid = 1; int_idx = 1; tick;
        chk("ack1_abort_pre", ack1, 1);
        wr(0, 8'h13);
        chk("abort_ack1", ack1, 0);
        chk("abort_imr", imr, 0);
        chk("abort_init_done", init_done, 0);
        inta_n = 1; tick;
        do_init(8'h13, 8'h40, 8'h00, 8'h03);

        // reset during ACK2
        inta_n = 0; tick; inta_n = 1; tick; inta_n = 0; tick;
        chk("ack2_pre_rst", ack2, 1);
        rst = 1; inta_n = 1; tick;
        chk_zero("rst_in_ack2");
        rst = 0; m_icw2 = 0; m_icw3 = 0; tick;

        // randomised configurations
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 2);
            sp   = (mode != 2);
            r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom); r4 = 8'($urandom);
            r1 = (r1 | 8'h10) & ~8'h02;
            if (mode == 0) r1 = r1 | 8'h02;
            do_init(r1, r2, r3, r4);
            for (int k = 0; k < 3; k++) ocw_rand();
            for (int k = 0; k < 2; k++) begin
                ri = 3'($urandom); rc = 3'($urandom);
                if ($urandom_range(0, 1) == 1) rc = m_icw3[2:0];
                hs(ri, ($urandom_range(0, 3) != 0), rc);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
